// File: rtl/adder_rr_scheduler.sv
// Round-robin front end that shares one registered adder between N requesters,
// issuing one operation at a time and timing out if the adder never answers.
module adder_rr_scheduler #(
  parameter int W       = 12,
  parameter int N       = 4,
  parameter int TIMEOUT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_y,
  output logic           rsp_err,
  output logic           busy,
  output logic           adder_start,
  output logic [W-1:0]   adder_a,
  output logic [W-1:0]   adder_b,
  input  logic [W-1:0]   adder_y,
  input  logic           adder_valid,
  output logic [1:0]     dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Handshake: requester i transfers when req_valid[i] & req_ready[i] at a
  // rising edge; rsp_valid[i] is a single-cycle strobe with no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [W-1:0]  adder_a_q, adder_a_d;
  logic [W-1:0]  adder_b_q, adder_b_d;
  logic [W-1:0]  rsp_y_q, rsp_y_d;
  logic          rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   cand;
  logic [IW:0]   next_ptr;

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!pick_found && req_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    next_ptr = {1'b0, grant_idx_q} + (IW+1)'(1);
    if (next_ptr >= (IW+1)'(N)) next_ptr = '0;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    adder_a_d   = adder_a_q;
    adder_b_d   = adder_b_q;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    rsp_valid   = '0;
    adder_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so a held request cannot show a grant during reset.
        if (pick_found && rst_n) begin
          req_ready[pick_idx] = 1'b1;
          grant_idx_d         = pick_idx;
          adder_a_d           = req_a[pick_idx*W +: W];
          adder_b_d           = req_b[pick_idx*W +: W];
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        adder_start = 1'b1;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as success.
        if (adder_valid) begin
          rsp_y_d   = adder_y;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_y_d   = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        rsp_valid[grant_idx_q] = 1'b1;
        rr_ptr_d               = next_ptr[IW-1:0];
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      adder_a_q   <= adder_a_d;
      adder_b_q   <= adder_b_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign adder_a   = adder_a_q;
  assign adder_b   = adder_b_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: requester model, adder stub with adjustable
// latency, and a scoreboard of expected responses keyed by arrival cycle.
module tb_adder_rr_scheduler;

  localparam int W       = 12;
  localparam int N       = 4;
  localparam int TIMEOUT = 4;
  localparam int IW      = 2;
  localparam int EW      = IW + 1 + W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  initial begin
    forever begin
      #5 clk = ~clk;
      if (clk) cyc++;
    end
  end

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a     = '0;
  logic [N*W-1:0] req_b     = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           rsp_err;
  logic           busy;
  logic           adder_start;
  logic [W-1:0]   adder_a;
  logic [W-1:0]   adder_b;
  logic [W-1:0]   adder_y     = '0;
  logic           adder_valid = 1'b0;
  logic [1:0]     dbg_state;

  adder_rr_scheduler #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b),
    .adder_y(adder_y), .adder_valid(adder_valid), .dbg_state(dbg_state)
  );

  // ---------------- shared state ----------------
  int           total = 0;
  int           bad   = 0;
  int           pend[N];
  logic [W-1:0] op_a[N];
  logic [W-1:0] op_b[N];
  bit           rand_ops = 1'b0;
  bit           stub_on  = 1'b1;
  bit           stray    = 1'b0;
  int           stub_lat = 1;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            gidx_log[$];
  int            gcyc_log[$];
  int            start_cyc = -1;
  logic [W-1:0]  start_a, start_b;
  logic [W-1:0]  last_rsp_y = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- adder stub ----------------
  int           cd = 0;
  logic [W-1:0] sy = '0;
  logic         sv_v;
  logic [W-1:0] sv_y;

  always @(posedge clk) begin
    sv_v = stray;
    sv_y = 12'h5A5;
    if (adder_start && stub_on) begin
      cd = stub_lat;
      sy = adder_a + adder_b;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        sv_v = 1'b1;
        sv_y = sy;
      end
    end
    adder_valid <= sv_v;
    adder_y     <= sv_y;
  end

  // ---------------- requester driver + scoreboard ----------------
  logic [N-1:0]  exp_rv;
  logic [EW-1:0] e;
  logic [N-1:0]  hs;
  int            hs_idx;
  logic [W-1:0]  ey;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_rv = '0;
        e      = '0;
        if (exp_q.size() > 0 && exp_cyc_q[0] == cyc) begin
          e = exp_q.pop_front();
          void'(exp_cyc_q.pop_front());
          exp_rv[e[EW-1 -: IW]] = 1'b1;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv != '0) begin
          check("rsp_y", 32'(rsp_y), 32'(e[W-1:0]));
          check("rsp_err", 32'(rsp_err), 32'(e[W]));
          last_rsp_y = rsp_y;
        end
        check("adder_start", 32'(adder_start), 32'(cyc == start_cyc));
        if (cyc == start_cyc) begin
          check("adder_a", 32'(adder_a), 32'(start_a));
          check("adder_b", 32'(adder_b), 32'(start_b));
        end
      end
      for (int i = 0; i < N; i++) begin
        req_valid[i]     = rst_n && (pend[i] > 0);
        req_a[i*W +: W]  = op_a[i];
        req_b[i*W +: W]  = op_b[i];
      end
      #1;
      hs = req_valid & req_ready;
      if (rst_n && hs != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        hs_idx = 0;
        for (int i = 0; i < N; i++) if (hs[i]) hs_idx = i;
        gidx_log.push_back(hs_idx);
        gcyc_log.push_back(cyc);
        start_cyc = cyc + 1;
        start_a   = op_a[hs_idx];
        start_b   = op_b[hs_idx];
        if (stub_on && stub_lat <= TIMEOUT) begin
          ey = op_a[hs_idx] + op_b[hs_idx];
          exp_q.push_back({IW'(hs_idx), 1'b0, ey});
          exp_cyc_q.push_back(cyc + 2 + stub_lat);
        end else begin
          exp_q.push_back({IW'(hs_idx), 1'b1, W'(0)});
          exp_cyc_q.push_back(cyc + 2 + TIMEOUT);
        end
        pend[hs_idx]--;
        if (rand_ops) begin
          op_a[hs_idx] = W'($urandom_range(0, 4095));
          op_b[hs_idx] = W'($urandom_range(0, 4095));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle();
    int  n    = 0;
    bit  done = 1'b0;
    int  psum;
    while (!done && n < 300) begin
      @(posedge clk); #2;
      n++;
      psum = 0;
      for (int i = 0; i < N; i++) psum += pend[i];
      done = !busy && exp_q.size() == 0 && psum == 0;
    end
    check("wait_idle", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    start_cyc = -1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic clear_log();
    gidx_log.delete();
    gcyc_log.delete();
  endtask

  // ---------------- directed sequence ----------------
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int k_lim;
  bit in_wait;

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      op_a[i] = '0;
      op_b[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_adder_start", 32'(adder_start), 32'd0);
    check("rst_adder_a", 32'(adder_a), 32'd0);
    check("rst_adder_b", 32'(adder_b), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single operation on requester 2
    @(posedge clk); #2;
    op_a[2] = 12'h3FF; op_b[2] = 12'h001; pend[2] = 1;
    @(negedge clk); #1;
    check("single_ready", 32'(req_ready), 32'h4);
    wait_idle();
    check("single_y", 32'(last_rsp_y), 32'h400);

    // Round-robin with all requesters held after reset
    do_reset();
    clear_log();
    rand_ops = 1'b1;
    for (int i = 0; i < N; i++) op_a[i] = W'($urandom_range(0, 4095));
    for (int i = 0; i < N; i++) op_b[i] = W'($urandom_range(0, 4095));
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    wait_idle();
    check("rr_count", 32'(gidx_log.size()), 32'd5);
    k_lim = (gidx_log.size() < 5) ? gidx_log.size() : 5;
    for (int k = 0; k < k_lim; k++) begin
      check("rr_order", 32'(gidx_log[k]), 32'(rr_exp[k]));
      if (k > 0) check("rr_gap", 32'(gcyc_log[k] - gcyc_log[k-1]), 32'd4);
    end

    // Pointer wrap: grant 2 leaves rr_ptr=3, then 3 wins over 0
    pend[2] = 1;
    wait_idle();
    clear_log();
    pend[0] = 1; pend[3] = 1;
    wait_idle();
    check("wrap_count", 32'(gidx_log.size()), 32'd2);
    if (gidx_log.size() == 2) begin
      check("wrap_first", 32'(gidx_log[0]), 32'd3);
      check("wrap_second", 32'(gidx_log[1]), 32'd0);
    end

    // Datapath wrap-around
    rand_ops = 1'b0;
    op_a[1] = 12'hFFF; op_b[1] = 12'h002; pend[1] = 1;
    wait_idle();
    check("wrap_y", 32'(last_rsp_y), 32'h001);

    // Timeout, then a normal op on the same requester
    stub_on = 1'b0;
    op_a[3] = 12'h123; op_b[3] = 12'h456; pend[3] = 1;
    wait_idle();
    check("timeout_y", 32'(last_rsp_y), 32'h000);
    check("timeout_err", 32'(rsp_err), 32'd1);
    stub_on = 1'b1;
    pend[3] = 1;
    wait_idle();
    check("after_timeout_y", 32'(last_rsp_y), 32'h579);
    check("after_timeout_err", 32'(rsp_err), 32'd0);

    // Result on the timeout cycle wins; one cycle later is an error
    stub_lat = 4;
    op_a[0] = 12'h0AA; op_b[0] = 12'h055; pend[0] = 1;
    wait_idle();
    check("late_ok_y", 32'(last_rsp_y), 32'h0FF);
    stub_lat = 5;
    pend[0] = 1;
    wait_idle();
    @(posedge clk); #2;
    check("late_err_y_held", 32'(rsp_y), 32'h000);
    check("late_err_flag", 32'(rsp_err), 32'd1);
    stub_lat = 1;

    // Stray adder_valid in IDLE is ignored
    @(posedge clk); #2 stray = 1'b1;
    @(posedge clk); #2 stray = 1'b0;
    @(posedge clk); #2;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_rsp_y", 32'(rsp_y), 32'h000);

    // Random burst
    rand_ops = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = $urandom_range(0, 3);
    wait_idle();

    // Reset during WAIT aborts the op; arbitration restarts at 0
    rand_ops = 1'b0;
    op_a[1] = 12'h321; op_b[1] = 12'h001; pend[1] = 1;
    wait_idle();
    op_a[2] = 12'h010; op_b[2] = 12'h020; pend[2] = 1;
    in_wait = 1'b0;
    for (int n = 0; n < 20 && !in_wait; n++) begin
      @(posedge clk); #2;
      in_wait = (dbg_state == 2'd2);
    end
    check("reach_wait", 32'(in_wait), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    start_cyc = -1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(adder_start), 32'd0);
    check("mid_rst_adder_a", 32'(adder_a), 32'd0);
    check("mid_rst_adder_b", 32'(adder_b), 32'd0);
    check("mid_rst_rsp_y", 32'(rsp_y), 32'd0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < N; i++) pend[i] = 1;
    wait_idle();
    check("post_rst_count", 32'(gidx_log.size()), 32'd4);
    if (gidx_log.size() > 0) check("post_rst_first", 32'(gidx_log[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
